// File: rtl/pipeline_stall_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pipeline_stall_ctrl_pkg
// Brief    : Shared state encoding and default sizes for the stall sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package pipeline_stall_ctrl_pkg;

    localparam logic [1:0] c_ST_RUN         = 2'd0;
    localparam logic [1:0] c_ST_MULDIV_WAIT = 2'd1;
    localparam logic [1:0] c_ST_MEM_WAIT    = 2'd2;

    localparam int c_MULDIV_TIMEOUT_DEF = 64;
    localparam int c_CNT_W_DEF          = 32;

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_perf_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : stall_perf_counter
// Brief    : Saturating event counter with enable, zeroed by reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module stall_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pipeline_stall_ctrl
// Brief    : Stall/bubble/flush sequencer for the 5-stage pipeline.
//            STALL_PERF_CNT_EN adds saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MULDIV_TIMEOUT = c_MULDIV_TIMEOUT_DEF,
    parameter int CNT_W          = c_CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ID_data_related_confict,
    input  logic             i_EXE_muldiv_start,
    input  logic             i_muldiv_done,
    input  logic             i_MEM_req,
    input  logic             i_MEM_ready,
    input  logic             i_EXE_branch_taken,
    output logic             o_IF_stall,
    output logic             o_ID_stall,
    output logic             o_EXE_stall,
    output logic             o_MEM_stall,
    output logic             o_ID_EXE_bubble,
    output logic             o_EXE_MEM_bubble,
    output logic             o_MEM_WB_bubble,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EXE_flush,
`ifdef STALL_PERF_CNT_EN
    output logic [CNT_W-1:0] o_load_use_cnt,
    output logic [CNT_W-1:0] o_muldiv_stall_cnt,
    output logic [CNT_W-1:0] o_mem_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
`endif
    output logic             o_muldiv_timeout
);

    localparam int c_TO_W = (MULDIV_TIMEOUT > 2) ? $clog2(MULDIV_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(MULDIV_TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_busy;
    logic              r_pending_flush;
    logic              r_timeout;
    logic [c_TO_W-1:0] r_to_cnt;

    logic w_in_run, w_in_md, w_mem_wait, w_md_stall, w_exe_stall;
    logic w_flush, w_load_use, w_to_hit, w_busy_nxt;

    assign w_in_run    = (r_state == c_ST_RUN);
    assign w_in_md     = (r_state == c_ST_MULDIV_WAIT);
    assign w_mem_wait  = i_MEM_req && !i_MEM_ready;
    assign w_md_stall  = !w_mem_wait &&
                         ((w_in_run && i_EXE_muldiv_start) || (w_in_md && !i_muldiv_done));
    assign w_exe_stall = w_mem_wait || w_md_stall;
    // A fresh or deferred branch flush goes out on the first cycle EXE is free.
    assign w_flush     = !w_exe_stall && (r_pending_flush || i_EXE_branch_taken);
    assign w_load_use  = w_in_run && !w_exe_stall && !w_flush && i_ID_data_related_confict;
    assign w_to_hit    = w_in_md && !i_muldiv_done && (r_to_cnt == c_TO_LAST);
    assign w_busy_nxt  = (w_in_run && i_EXE_muldiv_start) ? 1'b1 :
                         ((i_muldiv_done || w_to_hit) ? 1'b0 : r_busy);

    always_comb begin
        w_state_nxt = r_state;
        if (w_mem_wait) begin
            w_state_nxt = c_ST_MEM_WAIT;
        end else begin
            case (r_state)
                c_ST_RUN:         if (i_EXE_muldiv_start) w_state_nxt = c_ST_MULDIV_WAIT;
                c_ST_MULDIV_WAIT: if (i_muldiv_done || w_to_hit) w_state_nxt = c_ST_RUN;
                c_ST_MEM_WAIT:    w_state_nxt = w_busy_nxt ? c_ST_MULDIV_WAIT : c_ST_RUN;
                default:          w_state_nxt = c_ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= c_ST_RUN;
            r_busy          <= 1'b0;
            r_pending_flush <= 1'b0;
            r_timeout       <= 1'b0;
            r_to_cnt        <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_busy          <= w_busy_nxt;
            r_pending_flush <= w_exe_stall && (r_pending_flush || i_EXE_branch_taken);
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
            if ((r_busy && i_muldiv_done) || w_to_hit) begin
                r_to_cnt <= '0;
            end else if (w_in_md) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign o_IF_stall       = w_exe_stall || w_load_use;
    assign o_ID_stall       = w_exe_stall || w_load_use;
    assign o_EXE_stall      = w_exe_stall;
    assign o_MEM_stall      = w_mem_wait;
    assign o_ID_EXE_bubble  = w_load_use;
    assign o_EXE_MEM_bubble = w_md_stall;
    assign o_MEM_WB_bubble  = w_mem_wait;
    assign o_IF_ID_flush    = w_flush;
    assign o_ID_EXE_flush   = w_flush;
    assign o_muldiv_timeout = r_timeout;

`ifdef STALL_PERF_CNT_EN
    stall_perf_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_load_use), .o_cnt(o_load_use_cnt));
    stall_perf_counter #(.CNT_W(CNT_W)) u_muldiv_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_md_stall), .o_cnt(o_muldiv_stall_cnt));
    stall_perf_counter #(.CNT_W(CNT_W)) u_mem_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_mem_wait), .o_cnt(o_mem_stall_cnt));
    stall_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(w_flush), .o_cnt(o_flush_cnt));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_pipeline_stall_ctrl
// Brief    : Directed plus random stimulus against a behavioural stall model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int TO    = 8;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, conflict, md_start, md_done, mem_req, mem_ready, br_taken;
    logic if_stall, id_stall, exe_stall, mem_stall;
    logic id_exe_bub, exe_mem_bub, mem_wb_bub, if_id_fl, id_exe_fl, md_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt, md_cnt, mem_cnt, fl_cnt;
`endif

    pipeline_stall_ctrl #(.MULDIV_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .i_ID_data_related_confict (conflict),
        .i_EXE_muldiv_start        (md_start),
        .i_muldiv_done             (md_done),
        .i_MEM_req                 (mem_req),
        .i_MEM_ready               (mem_ready),
        .i_EXE_branch_taken        (br_taken),
        .o_IF_stall                (if_stall),
        .o_ID_stall                (id_stall),
        .o_EXE_stall               (exe_stall),
        .o_MEM_stall               (mem_stall),
        .o_ID_EXE_bubble           (id_exe_bub),
        .o_EXE_MEM_bubble          (exe_mem_bub),
        .o_MEM_WB_bubble           (mem_wb_bub),
        .o_IF_ID_flush             (if_id_fl),
        .o_ID_EXE_flush            (id_exe_fl),
`ifdef STALL_PERF_CNT_EN
        .o_load_use_cnt            (lu_cnt),
        .o_muldiv_stall_cnt        (md_cnt),
        .o_mem_stall_cnt           (mem_cnt),
        .o_flush_cnt               (fl_cnt),
`endif
        .o_muldiv_timeout          (md_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Model: the sequencer's mode follows from "was memory waiting last cycle"
    // and "is a mul/div outstanding"; everything else is per-cycle rules.
    bit      m_prev_mem, m_busy, m_pending, m_timeout;
    int      m_age;
    longint  m_cnt[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_mem = 0; m_busy = 0; m_pending = 0; m_timeout = 0; m_age = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic step(input bit r, input bit req, input bit rdy, input bit st,
                        input bit dn, input bit cf, input bit br);
        bit mem, run, md, md_st, ex, fl, lu, hit;
        logic [9:0] exp_v, obs_v;
        @(posedge clk);
        #1;
        rst = r; mem_req = req; mem_ready = rdy; md_start = st;
        md_done = dn; conflict = cf; br_taken = br;
        #4;
        mem   = req && !rdy;
        run   = !m_prev_mem && !m_busy;
        md    = !m_prev_mem && m_busy;
        md_st = !mem && ((run && st) || (md && !dn));
        ex    = mem || md_st;
        fl    = !ex && (m_pending || br);
        lu    = run && !ex && !fl && cf;
        exp_v = {ex || lu, ex || lu, ex, mem, lu, md_st, mem, fl, fl, m_timeout};
        obs_v = {if_stall, id_stall, exe_stall, mem_stall, id_exe_bub, exe_mem_bub,
                 mem_wb_bub, if_id_fl, id_exe_fl, md_timeout};
        check("outputs", 64'(obs_v), 64'(exp_v));
`ifdef STALL_PERF_CNT_EN
        check("load_use_cnt", 64'(lu_cnt), m_cnt[0]);
        check("muldiv_cnt", 64'(md_cnt), m_cnt[1]);
        check("mem_cnt", 64'(mem_cnt), m_cnt[2]);
        check("flush_cnt", 64'(fl_cnt), m_cnt[3]);
`endif
        cycle++;
        if (r) begin
            model_reset();
        end else begin
            hit = md && !dn && (m_age == TO - 1);
            if ((m_busy && dn) || hit) m_age = 0;
            else if (md) m_age++;
            if (run && st) m_busy = 1;
            else if (dn || hit) m_busy = 0;
            if (hit) m_timeout = 1;
            m_pending  = ex && (m_pending || br);
            m_prev_mem = mem;
            if (lu    && m_cnt[0] < (64'd1 << CNT_W) - 1) m_cnt[0]++;
            if (md_st && m_cnt[1] < (64'd1 << CNT_W) - 1) m_cnt[1]++;
            if (mem   && m_cnt[2] < (64'd1 << CNT_W) - 1) m_cnt[2]++;
            if (fl    && m_cnt[3] < (64'd1 << CNT_W) - 1) m_cnt[3]++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; conflict = 0; md_start = 0; md_done = 0;
        mem_req = 0; mem_ready = 0; br_taken = 0;
        model_reset();
        repeat (2) @(posedge clk);

        idle(2);                                   // reset state
        step(0, 0, 0, 0, 0, 1, 0); idle(1);        // load-use
        step(0, 0, 0, 1, 0, 0, 0); idle(4);        // mul/div completes
        step(0, 0, 0, 0, 1, 0, 0); idle(1);
        step(0, 0, 0, 1, 0, 0, 0); idle(12);       // mul/div timeout
        check("timeout_sticky", 64'(md_timeout), 64'd1);
        step(1, 0, 0, 0, 0, 0, 0); idle(1);
        repeat (3) step(0, 1, 0, 0, 0, 0, 0);      // memory wait
        step(0, 1, 1, 0, 0, 0, 0); idle(1);
        step(0, 0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 0, 1);   // deferred branch
        idle(1); step(0, 0, 0, 0, 1, 0, 0); idle(2);
        step(0, 1, 0, 1, 0, 0, 0); step(0, 1, 0, 0, 0, 0, 0);   // start under MEM wait
        step(0, 1, 1, 0, 0, 0, 0); idle(2); step(0, 0, 0, 0, 1, 0, 0); idle(1);
        step(0, 0, 0, 0, 0, 1, 1); idle(1);       // flush beats load-use
        step(0, 1, 0, 0, 0, 0, 1); step(0, 1, 0, 0, 0, 0, 0);   // reset mid-stall
        step(1, 1, 0, 0, 0, 0, 0); idle(2);

        for (int i = 0; i < 3000; i++) begin
            bit r, req, rdy;
            r   = ($urandom_range(199) == 0);
            req = ($urandom_range(9) < 3);
            rdy = ($urandom_range(1) == 1);
            step(r, req, rdy, $urandom_range(9) == 0, $urandom_range(99) < 15,
                 $urandom_range(4) == 0, $urandom_range(6) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
